// File: rtl/keypad_scan.sv
// Scanner for a 4x4 hex matrix keypad: drives one column low at a time,
// samples the rows, debounces whole-keypad frames and emits hex key codes
// plus an eight-digit shift register suitable for the seven-segment driver.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] entry
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StHeld,
    StRelease
  } state_e;

  // Synchronizer, scan and snapshot state
  logic [3:0]       row_meta_q, row_sync_q;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_drv_q, col_drv_d;
  logic [15:0]      snap_q, snap_d;

  // Debounce state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]      cand_q, cand_d;

  // Output registers
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic [31:0] entry_q, entry_d;

  // Frame classification
  logic        slot_last;
  logic        frame_end;
  logic [15:0] frame_snap;
  logic [4:0]  hit_cnt;
  logic [3:0]  hit_idx;
  logic [3:0]  hit_key;
  logic        cls_none;
  logic        cls_one;
  logic        accept;

  assign slot_last = (slot_q == SlotLast);
  assign frame_end = slot_last && (col_q == 2'd3);

  // Two-flop synchronizer for the asynchronous row lines (idle high)
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= ROW;
      row_sync_q <= row_meta_q;
    end
  end

  // Slot counter, column index and registered active-low column drive
  always_comb begin
    slot_d    = slot_last ? '0 : slot_q + SlotW'(1);
    col_d     = slot_last ? col_q + 2'd1 : col_q;
    col_drv_d = ~(4'b0001 << col_q);
  end

  // Snapshot: column sample on each slot's last cycle, cleared as a frame ends
  always_comb begin
    snap_d = snap_q;
    if (frame_end) begin
      snap_d = '0;
    end else if (slot_last) begin
      snap_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
    end
  end

  // Full frame as seen on the frame-end cycle: column 3 comes straight from the synchronizer
  always_comb begin
    frame_snap        = snap_q;
    frame_snap[15:12] = ~row_sync_q;
  end

  // Count set bits and remember the index of the (last) one found
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_snap[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  // Snapshot index is 4*col+row; key code is 4*row+col, so swap the halves
  assign hit_key  = {hit_idx[1:0], hit_idx[3:2]};
  assign cls_none = (hit_cnt == 5'd0);
  assign cls_one  = (hit_cnt == 5'd1);
  assign cnt_inc  = cnt_q + CntOne;

  // Scan state registers
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      slot_q    <= '0;
      col_q     <= 2'd0;
      col_drv_q <= 4'b1110;
      snap_q    <= '0;
    end else begin
      slot_q    <= slot_d;
      col_q     <= col_d;
      col_drv_q <= col_drv_d;
      snap_q    <= snap_d;
    end
  end

  // Debounce FSM: only frame ends move it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (cls_one) begin
            cand_d = hit_key;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              state_d = StPress;
              cnt_d   = CntOne;
            end
          end
        end
        StPress: begin
          if (cls_one && (hit_key == cand_q)) begin
            if (cnt_inc == CntDone) begin
              accept  = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (cls_one) begin
            // A different single key restarts the debounce with the new candidate
            cand_d = hit_key;
            cnt_d  = CntOne;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (cls_none) begin
            if (DEBOUNCE == 1) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StRelease: begin
          if (cls_none) begin
            if (cnt_inc == CntDone) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StHeld;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Debounce state registers
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Output next state: clear beats a simultaneous accept for entry only
  always_comb begin
    key_code_d  = accept ? hit_key : key_code_q;
    key_valid_d = accept;
    entry_d     = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (accept) begin
      entry_d = {entry_q[27:0], hit_key};
    end
  end

  // Output registers
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      entry_q     <= '0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
    end
  end

  assign COL       = col_drv_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a behavioural keypad drives ROW from COL and a
// frame-level debounce model predicts pulses, codes and the entry word.
module tb_keypad_scan;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned Debounce = 3;
  localparam int unsigned FrameCyc = 4 * ScanDiv;

  logic        clk;
  logic        resetn;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clear;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [31:0] entry;

  // Keys currently held, bit k = key code k (row = k[3:2], col = k[1:0])
  logic [15:0] pressed;

  int n_total;
  int n_bad;
  int pulses;
  bit mon_en;
  logic prev_kv;

  // Reference model state
  bit          m_held;
  int          m_run;
  logic [3:0]  m_run_key;
  int          m_rel;
  logic [3:0]  m_code;
  logic [31:0] m_entry;
  int          m_pulses;

  keypad_scan #(
    .SCAN_DIV(ScanDiv),
    .DEBOUNCE(Debounce)
  ) dut (
    .CLK100MHZ(clk),
    .resetn   (resetn),
    .ROW      (row),
    .COL      (col),
    .clear    (clear),
    .key_code (key_code),
    .key_valid(key_valid),
    .entry    (entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col[c] && pressed[4*r+c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle properties: single active column, no back-to-back pulses
  always @(negedge clk) begin
    if (mon_en) begin
      check("col_onehot", 32'($countones(~col)), 32'd1);
      if (resetn) begin
        if (key_valid) begin
          pulses++;
          check("kv_gap", {31'd0, prev_kv}, 32'd0);
        end
        prev_kv = key_valid;
      end else begin
        prev_kv = 1'b0;
      end
    end
  end

  task automatic model_reset();
    m_held    = 0;
    m_run     = 0;
    m_run_key = '0;
    m_rel     = 0;
    m_code    = '0;
    m_entry   = '0;
  endtask

  // One full frame with a fixed key set; clr is raised on the frame's last cycle
  task automatic run_frame(input logic [15:0] mask, input logic clr);
    logic       exp_v;
    int         n;
    logic [3:0] k;
    pressed = mask;
    repeat (FrameCyc - 1) @(posedge clk);
    #1 clear = clr;
    @(posedge clk);
    #1 clear = 1'b0;
    n = $countones(mask);
    k = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
    exp_v = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && k == m_run_key) m_run++;
        else begin
          m_run     = 1;
          m_run_key = k;
        end
        if (m_run == Debounce) begin
          exp_v  = 1'b1;
          m_held = 1;
          m_rel  = 0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == Debounce) begin
          m_held = 0;
          m_rel  = 0;
        end
      end else begin
        m_rel = 0;
      end
    end
    if (exp_v) begin
      m_pulses++;
      m_code  = k;
      m_entry = {m_entry[27:0], k};
    end
    if (clr) m_entry = '0;
    check("key_valid", {31'd0, key_valid}, {31'd0, exp_v});
    check("key_code", {28'd0, key_code}, {28'd0, m_code});
    check("entry", entry, m_entry);
  endtask

  task automatic hold_release(input logic [15:0] mask, input int hold, input int rel);
    for (int i = 0; i < hold; i++) run_frame(mask, 1'b0);
    for (int i = 0; i < rel; i++) run_frame(16'h0, 1'b0);
  endtask

  initial begin
    logic [3:0]  ec;
    logic [15:0] cur;
    logic [3:0]  digits [9];
    int          base;
    int          r;
    int          r2;

    n_total  = 0;
    n_bad    = 0;
    pulses   = 0;
    m_pulses = 0;
    prev_kv  = 1'b0;
    mon_en   = 0;
    pressed  = '0;
    clear    = 1'b0;
    resetn   = 1'b1;
    model_reset();
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1;
    check("rst_col", {28'd0, col}, 32'h0000000E);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_entry", entry, 32'd0);
    resetn = 1'b1;

    // Column scan over the first two frames, all rows released
    check("scan_col0", {28'd0, col}, 32'h0000000E);
    for (int m = 1; m <= 2 * FrameCyc; m++) begin
      @(posedge clk);
      #1;
      ec = ~(4'b0001 << (((m - 1) / ScanDiv) % 4));
      check("scan_col", {28'd0, col}, {28'd0, ec});
    end
    for (int f = 0; f < 98; f++) run_frame(16'h0, 1'b0);
    check("idle_pulses", pulses, 0);

    // Single key at row 2 / col 1 held well past acceptance
    base = pulses;
    hold_release(16'h1 << 9, 6, 3);
    check("single_pulses", pulses - base, 1);
    check("single_code", {28'd0, key_code}, 32'h9);
    check("single_entry", entry, 32'h00000009);

    // Nine digits: the oldest falls off the eight-digit word
    digits = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
    base = pulses;
    for (int d = 0; d < 9; d++) hold_release(16'h1 << digits[d], 4, 4);
    check("digits_pulses", pulses - base, 9);
    check("digits_entry", entry, 32'h2345678A);

    // Bounce on key 5, then a stable hold
    base = pulses;
    for (int f = 0; f < 10; f++) run_frame((f % 2 == 0) ? (16'h1 << 5) : 16'h0, 1'b0);
    check("bounce_pulses", pulses - base, 0);
    hold_release(16'h1 << 5, 4, 3);
    check("bounce_stable", pulses - base, 1);
    check("bounce_code", {28'd0, key_code}, 32'h5);

    // Two keys together never accept; a second key while held adds nothing
    base = pulses;
    hold_release((16'h1 << 3) | (16'h1 << 12), 4, 3);
    check("multi_none", pulses - base, 0);
    hold_release(16'h1 << 3, 3, 0);
    hold_release((16'h1 << 3) | (16'h1 << 12), 3, 3);
    check("multi_one", pulses - base, 1);
    check("multi_code", {28'd0, key_code}, 32'h3);

    // Clear on the same edge as the accept of key F
    run_frame(16'h1 << 15, 1'b0);
    run_frame(16'h1 << 15, 1'b0);
    run_frame(16'h1 << 15, 1'b1);
    check("clr_entry", entry, 32'd0);
    check("clr_code", {28'd0, key_code}, 32'hF);
    hold_release(16'h0, 0, 3);

    // Reset in the middle of the third debounce frame
    base = pulses;
    hold_release(16'h1 << 6, 2, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_col", {28'd0, col}, 32'h0000000E);
    check("midrst_code", {28'd0, key_code}, 32'd0);
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_entry", entry, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    hold_release(16'h1 << 6, 2, 0);
    check("midrst_nopulse", pulses - base, 0);
    hold_release(16'h1 << 6, 1, 3);
    check("midrst_pulse", pulses - base, 1);
    check("midrst_code6", {28'd0, key_code}, 32'h6);

    // Random key activity with persistence so debounces complete
    cur = '0;
    for (int f = 0; f < 120; f++) begin
      r = $urandom_range(0, 99);
      if (r >= 65) begin
        r2 = $urandom_range(0, 9);
        if (r2 < 3) cur = '0;
        else if (r2 < 8) cur = 16'h1 << $urandom_range(0, 15);
        else cur = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      end
      run_frame(cur, ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0);
    end
    hold_release(16'h0, 0, 4);

    check("total_pulses", pulses, m_pulses);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
